// File: rtl/dpram_pkg.sv
// rtl/dpram_pkg.sv - shared constants and FSM encoding for the dual-port RAM burst reader
package dpram_pkg;

    localparam int DPRAM_AWIDTH = 11;
    localparam int DPRAM_DWIDTH = 40;
    localparam int DPRAM_WORDS  = 2048;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/stream_buf2.sv
// rtl/stream_buf2.sv - 2-entry register FIFO; entry 0 is always the head
module stream_buf2 #(
    parameter int DWIDTH = 40
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        occ,
    output logic [DWIDTH-1:0] head_data,
    output logic              head_valid
);

    logic [DWIDTH-1:0] entry0;
    logic [DWIDTH-1:0] entry1;
    logic              pop_ok;

    assign pop_ok     = pop && (occ != 2'd0);
    assign head_data  = entry0;
    assign head_valid = (occ != 2'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            entry0 <= '0;
            entry1 <= '0;
            occ    <= 2'd0;
        end else begin
            case ({push, pop_ok})
                2'b10: begin
                    if (occ == 2'd0) entry0 <= push_data;
                    else             entry1 <= push_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    occ    <= occ - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop keeps occupancy; the new word lands behind any survivor.
                    if (occ == 2'd1) begin
                        entry0 <= push_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dpram_burst_reader.sv
// rtl/dpram_burst_reader.sv - reads a wrapping burst from RAM port B and streams it out with backpressure
module dpram_burst_reader
    import dpram_pkg::*;
#(
    parameter int AWIDTH    = DPRAM_AWIDTH,
    parameter int NUM_WORDS = DPRAM_WORDS,
    parameter int DWIDTH    = DPRAM_DWIDTH
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH:0]   num_words,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] ram_addr,
    output logic              ram_wren,
    input  logic [DWIDTH-1:0] ram_rdata,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam logic [AWIDTH:0] MAX_LEN = (AWIDTH + 1)'(NUM_WORDS);

    state_t            state;
    state_t            state_nxt;
    logic [AWIDTH-1:0] addr_cnt;
    logic [AWIDTH:0]   issue_cnt;
    logic [AWIDTH:0]   accept_cnt;
    logic [AWIDTH:0]   len_eff;
    logic              inflight;
    logic              done_q;
    logic [1:0]        occ;
    logic              pop;
    logic              issue;
    logic [2:0]        pending;
    logic [2:0]        room_limit;

    assign len_eff    = (num_words > MAX_LEN) ? MAX_LEN : num_words;
    assign pop        = out_valid && out_ready;
    // Words buffered or on their way must stay below 2 after this cycle's pop.
    assign pending    = {1'b0, occ} + {2'b00, inflight};
    assign room_limit = 3'd2 + {2'b00, pop};
    assign issue      = (state == S_READ) && (issue_cnt != '0) && (pending < room_limit);

    assign busy     = (state != S_IDLE);
    assign done     = done_q;
    assign ram_addr = addr_cnt;
    assign ram_wren = 1'b0;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start && (len_eff != '0))                      state_nxt = S_READ;
            S_READ:  if (issue && (issue_cnt == (AWIDTH + 1)'(1)))      state_nxt = S_DRAIN;
            S_DRAIN: if (pop && (accept_cnt == (AWIDTH + 1)'(1)))       state_nxt = S_IDLE;
            default:                                                    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            addr_cnt   <= '0;
            issue_cnt  <= '0;
            accept_cnt <= '0;
            inflight   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            done_q   <= 1'b0;
            if ((state == S_IDLE) && start) begin
                addr_cnt   <= base_addr;
                issue_cnt  <= len_eff;
                accept_cnt <= len_eff;
                done_q     <= (len_eff == '0);
            end
            if (issue) begin
                addr_cnt  <= addr_cnt + 1'b1;
                issue_cnt <= issue_cnt - 1'b1;
            end
            if (pop) begin
                accept_cnt <= accept_cnt - 1'b1;
            end
            if ((state == S_DRAIN) && pop && (accept_cnt == (AWIDTH + 1)'(1))) begin
                done_q <= 1'b1;
            end
        end
    end

    stream_buf2 #(
        .DWIDTH(DWIDTH)
    ) u_buf (
        .clk        (clk),
        .resetn     (resetn),
        .push       (inflight),
        .push_data  (ram_rdata),
        .pop        (pop),
        .occ        (occ),
        .head_data  (out_data),
        .head_valid (out_valid)
    );

endmodule
